// File: rtl/image_scan_ctrl.sv
// image_scan_ctrl
// Frame-scan sequencer. A start pulse latches the enhancement mode and walks
// the stored image in raster order. It issues one read per pixel to a
// synchronous (1-cycle) pixel memory and presents each pixel to the
// processing stage over a valid/ready handshake. Line and frame markers
// travel with each pixel. A one-cycle done pulse marks the end of the frame.
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous reset, active low
//   start      frame start request, only sampled while idle
//   abort      cancel the current frame (no done pulse)
//   op_mode    requested operation: 0 orig, 1 invert, 2 brightness, 3 threshold
//   pix_ready  processing stage can accept a pixel
//   busy       frame in progress (RUN or DRAIN)
//   done       one-cycle pulse after the last pixel is accepted
//   op_sel     op_mode captured at start
//   mem_rd_en  pixel-memory read strobe
//   mem_addr   pixel-memory address = phys_row*WIDTH + col
//   pix_valid  memory data and sideband are valid
//   out_row    logical row of the presented pixel
//   out_col    column of the presented pixel
//   line_end   presented pixel is the last one of its line
//   frame_end  presented pixel is the last one of the frame
module image_scan_ctrl #(
  parameter int WIDTH  = 256,
  parameter int HEIGHT = 256,
  parameter int ADDR_W = 16,
  parameter int FLIP_V = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        op_mode,
  input  logic              pix_ready,
  output logic              busy,
  output logic              done,
  output logic [1:0]        op_sel,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              pix_valid,
  output logic [9:0]        out_row,
  output logic [10:0]       out_col,
  output logic              line_end,
  output logic              frame_end
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [9:0]  row;
  logic [10:0] col;
  logic [9:0]  phys_row;
  logic        col_last;
  logic        last_pos;
  logic        advance;
  logic        rd_issue;
  logic        start_frame;
  logic        final_xfer;

  assign col_last = (col == 11'(WIDTH - 1));
  assign last_pos = col_last && (row == 10'(HEIGHT - 1));

  // The pipeline slot (memory output register + sideband) can take a new
  // read when it is empty or its current pixel is leaving this cycle.
  assign advance = !pix_valid || pix_ready;

  // Bottom-up storage mirrors the physical line index.
  assign phys_row = (FLIP_V != 0) ? (10'(HEIGHT - 1) - row) : row;

  // Address is only meaningful while scanning; it reads as zero otherwise.
  assign mem_addr = (state == RUN)
                    ? ADDR_W'(32'(phys_row) * 32'(WIDTH) + 32'(col))
                    : '0;

  assign mem_rd_en = rd_issue;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Abort is checked first in every active state so it overrides reads,
  // transfers and completion in the same cycle.
  always_comb begin
    next_state  = state;
    rd_issue    = 1'b0;
    start_frame = 1'b0;
    final_xfer  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          next_state  = RUN;
          start_frame = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          next_state = IDLE;
        end else if (advance) begin
          rd_issue = 1'b1;
          if (last_pos) begin
            next_state = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (abort) begin
          next_state = IDLE;
        end else if (pix_valid && pix_ready) begin
          final_xfer = 1'b1;
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Scan counters and the sideband register that travels with the memory
  // read data. After the last read the counters park at zero instead of
  // running past the frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row       <= '0;
      col       <= '0;
      op_sel    <= '0;
      done      <= 1'b0;
      pix_valid <= 1'b0;
      out_row   <= '0;
      out_col   <= '0;
      line_end  <= 1'b0;
      frame_end <= 1'b0;
    end else begin
      done <= final_xfer;
      if (start_frame) begin
        op_sel <= op_mode;
        row    <= '0;
        col    <= '0;
      end
      if (abort && (state != IDLE)) begin
        pix_valid <= 1'b0;
        row       <= '0;
        col       <= '0;
      end else if (rd_issue) begin
        pix_valid <= 1'b1;
        out_row   <= row;
        out_col   <= col;
        line_end  <= col_last;
        frame_end <= last_pos;
        if (last_pos) begin
          row <= '0;
          col <= '0;
        end else if (col_last) begin
          col <= '0;
          row <= row + 10'd1;
        end else begin
          col <= col + 11'd1;
        end
      end else if (pix_valid && pix_ready) begin
        pix_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_image_scan_ctrl.sv
// tb_image_scan_ctrl
// Self-checking bench for image_scan_ctrl with a 4x2 image. Two instances
// share all inputs: one stores lines bottom-up, the other top-down. A
// reference model built from raster-order pixel indices predicts reads,
// addresses, sideband and done timing under random back-pressure.
module tb_image_scan_ctrl;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int WH = W * H;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [1:0]  op_mode;
  logic        pix_ready;

  logic        busy, done, mem_rd_en, pix_valid, line_end, frame_end;
  logic [1:0]  op_sel;
  logic [15:0] mem_addr;
  logic [9:0]  out_row;
  logic [10:0] out_col;

  logic        busy0, done0, mem_rd_en0, pix_valid0, line_end0, frame_end0;
  logic [1:0]  op_sel0;
  logic [15:0] mem_addr0;
  logic [9:0]  out_row0;
  logic [10:0] out_col0;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  image_scan_ctrl #(.WIDTH(W), .HEIGHT(H), .ADDR_W(16), .FLIP_V(1)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .op_mode(op_mode), .pix_ready(pix_ready), .busy(busy), .done(done),
    .op_sel(op_sel), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .pix_valid(pix_valid), .out_row(out_row), .out_col(out_col),
    .line_end(line_end), .frame_end(frame_end)
  );

  image_scan_ctrl #(.WIDTH(W), .HEIGHT(H), .ADDR_W(16), .FLIP_V(0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .op_mode(op_mode), .pix_ready(pix_ready), .busy(busy0), .done(done0),
    .op_sel(op_sel0), .mem_rd_en(mem_rd_en0), .mem_addr(mem_addr0),
    .pix_valid(pix_valid0), .out_row(out_row0), .out_col(out_col0),
    .line_end(line_end0), .frame_end(frame_end0)
  );

  // Raster index k -> memory address for either storage order.
  function automatic int expAddr(input int k, input bit flip);
    int r;
    int c;
    r = k / W;
    c = k % W;
    return ((flip ? (H - 1 - r) : r) * W + c);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic a, input logic r,
                               input logic [1:0] m);
    start     = s;
    abort     = a;
    pix_ready = r;
    op_mode   = m;
  endtask

  task automatic checkReset();
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_pix_valid", pix_valid, 0);
    checkOutput("rst_mem_rd_en", mem_rd_en, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_op_sel", op_sel, 0);
    checkOutput("rst_out_row", out_row, 0);
    checkOutput("rst_out_col", out_col, 0);
    checkOutput("rst_line_end", line_end, 0);
    checkOutput("rst_frame_end", frame_end, 0);
    checkOutput("rst_busy0", busy0, 0);
    checkOutput("rst_mem_addr0", mem_addr0, 0);
    checkOutput("rst_pix_valid0", pix_valid0, 0);
  endtask

  task automatic checkIdle();
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_done", done, 0);
    checkOutput("idle_pix_valid", pix_valid, 0);
    checkOutput("idle_mem_rd_en", mem_rd_en, 0);
    checkOutput("idle_mem_addr", mem_addr, 0);
    checkOutput("idle_busy0", busy0, 0);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      applyStimulus(1'b0, 1'b0, 1'b1, 2'($urandom_range(0, 3)));
      #4;
      checkIdle();
    end
  endtask

  // Runs one frame starting from IDLE. Called with at least 1 time unit
  // before the next rising edge. readyPct sets random back-pressure;
  // stallPix/stallLen force ready low while that pixel is presented;
  // abortAt (cycle index after the start edge, -1 for none) cancels.
  task automatic doFrame(input logic [1:0] mode, input int readyPct,
                         input int stallPix, input int stallLen,
                         input int abortAt);
    int c, issued, mpix, stallCnt;
    bit mvalid, rdy, expRd, xfer, finished;
    applyStimulus(1'b1, 1'b0, 1'b1, mode);
    @(posedge clk);
    #1;
    c = 0; issued = 0; mpix = 0; stallCnt = 0;
    mvalid = 0; finished = 0;
    while (!finished && c < 200) begin
      rdy = (int'($urandom_range(0, 99)) < readyPct);
      if (stallPix >= 0 && mvalid && mpix == stallPix && stallCnt < stallLen) begin
        rdy = 1'b0;
        stallCnt++;
      end
      applyStimulus((c == abortAt) ? 1'b0 : 1'($urandom_range(0, 1)),
                    (c == abortAt), rdy, 2'($urandom_range(0, 3)));
      expRd = (c != abortAt) && (issued < WH) && (!mvalid || rdy);
      #4;
      checkOutput("busy", busy, 1);
      checkOutput("done_early", done, 0);
      checkOutput("op_sel", op_sel, mode);
      checkOutput("pix_valid", pix_valid, mvalid);
      checkOutput("pix_valid0", pix_valid0, mvalid);
      checkOutput("mem_rd_en", mem_rd_en, expRd);
      checkOutput("mem_rd_en0", mem_rd_en0, expRd);
      if (expRd) begin
        checkOutput("mem_addr", mem_addr, expAddr(issued, 1'b1));
        checkOutput("mem_addr0", mem_addr0, expAddr(issued, 1'b0));
      end
      if (mvalid) begin
        checkOutput("out_row", out_row, mpix / W);
        checkOutput("out_col", out_col, mpix % W);
        checkOutput("line_end", line_end, (mpix % W) == W - 1);
        checkOutput("frame_end", frame_end, mpix == WH - 1);
        checkOutput("out_row0", out_row0, mpix / W);
      end
      if (c == abortAt) begin
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b0, 1'b1, mode);
        #4;
        checkOutput("abort_pix_valid", pix_valid, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        return;
      end
      xfer = mvalid && rdy;
      if (xfer && mpix == WH - 1) finished = 1'b1;
      if (expRd) begin
        mpix   = issued;
        issued++;
        mvalid = 1'b1;
      end else if (xfer) begin
        mvalid = 1'b0;
      end
      @(posedge clk);
      #1;
      c++;
    end
    if (!finished) begin
      checkOutput("frame_timeout", 0, 1);
      return;
    end
    applyStimulus(1'b0, 1'b0, 1'b1, mode);
    #4;
    checkOutput("done_pulse", done, 1);
    checkOutput("done_busy", busy, 0);
    checkOutput("done_pix_valid", pix_valid, 0);
    checkOutput("done_pulse0", done0, 1);
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd0);
    reset = 1'b0;
    #3;
    checkReset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    idleCycles(2);

    $display("[TB] nominal frame, full throughput");
    doFrame(2'd0, 100, -1, 0, -1);
    idleCycles(1);

    $display("[TB] three-cycle stall on the second pixel");
    doFrame(2'd3, 100, 1, 3, -1);
    idleCycles(1);

    $display("[TB] abort on the fifth read cycle, then restart");
    doFrame(2'd2, 100, -1, 0, 4);
    idleCycles(2);
    doFrame(2'd1, 100, -1, 0, -1);

    $display("[TB] back-to-back frame started on the done cycle");
    doFrame(2'd2, 100, -1, 0, -1);
    idleCycles(1);

    $display("[TB] random back-pressure and aborts");
    for (int i = 0; i < 8; i++) begin
      doFrame(2'($urandom_range(0, 3)), 30 + 8 * i, -1, 0,
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : -1);
      idleCycles(1);
    end

    $display("[TB] reset while draining");
    applyStimulus(1'b1, 1'b0, 1'b1, 2'd3);
    @(posedge clk);
    #1;
    for (int k = 0; k < WH; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 2'd0);
      @(posedge clk);
      #1;
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0);
    #2;
    checkOutput("drain_busy", busy, 1);
    checkOutput("drain_pix_valid", pix_valid, 1);
    checkOutput("drain_frame_end", frame_end, 1);
    checkOutput("drain_mem_rd_en", mem_rd_en, 0);
    #1;
    reset = 1'b0;
    #1;
    checkReset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checkIdle();
    doFrame(2'd1, 100, -1, 0, -1);
    idleCycles(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/image_scan_ctrl.md
# image_scan_ctrl

Frame-scan sequencer for the image-enhancement datapath. On a start pulse it latches the enhancement mode and walks the stored image in raster order. It issues one read per pixel to the synchronous pixel memory and presents each pixel to the processing stage with a valid/ready handshake. Line and frame markers travel with each pixel, and a one-cycle done pulse marks the end of the frame; abort cancels the frame without a done pulse.

## Interface
Parameters:
- WIDTH, 256, pixels per line
- HEIGHT, 256, lines per frame
- ADDR_W, 16, pixel-memory address width; must satisfy 2^ADDR_W ≥ WIDTH*HEIGHT
- FLIP_V, 1, 1 = memory stores lines bottom-up, so the physical line read is HEIGHT-1-row; 0 = physical line equals row

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  frame start request; sampled only in IDLE
- abort  in  1  cancel the current frame
- op_mode  in  2  0 original, 1 invert, 2 brightness, 3 threshold
- pix_ready  in  1  processing stage can accept a pixel
- busy  out  1  high in RUN or DRAIN
- done  out  1  one-cycle pulse after the last pixel is accepted
- op_sel  out  2  op_mode latched at start; drives the datapath operation select
- mem_rd_en  out  1  pixel-memory read strobe
- mem_addr  out  ADDR_W  pixel index = phys_row*WIDTH + col
- pix_valid  out  1  memory read data and sideband signals are valid
- out_row  out  10  logical row of the presented pixel
- out_col  out  11  column of the presented pixel
- line_end  out  1  presented pixel has col = WIDTH-1
- frame_end  out  1  presented pixel is the last pixel of the frame

## Operation
- Pixel memory contract:
  - synchronous read, 1-cycle latency
  - memory output register updates only when mem_rd_en = 1, so read data holds while stalled
- Handshake terms:
  - advance = !pix_valid || pix_ready
  - a pixel transfers in any cycle with pix_valid && pix_ready
- FSM states: IDLE, RUN, DRAIN
- IDLE:
  - start=1 and abort=0 → RUN; latch op_sel←op_mode; row←0, col←0
  - start while busy is ignored
- RUN:
  - mem_rd_en = advance (combinational), mem_addr from the current row/col
  - on each issued read: col increments; at col = WIDTH-1, col←0 and row increments
  - on the read of (HEIGHT-1, WIDTH-1) → DRAIN; counters do not wrap past the frame
- DRAIN:
  - no reads issued
  - when the final pixel transfers → IDLE and done=1 for one cycle
- abort = 1 in RUN or DRAIN:
  - next state IDLE; pix_valid←0
  - no done pulse; row/col←0
  - abort wins over all other events in the same cycle
- Sideband pipeline:
  - on an issued read, pix_valid←1 and out_row/out_col/line_end/frame_end load the issued coordinates
  - on a transfer with no new read, pix_valid←0
  - when stalled (pix_valid && !pix_ready), everything holds
- Address arithmetic:
  - phys_row = FLIP_V ? HEIGHT-1-row : row
  - product truncated to ADDR_W

## Timing
- Reset values: busy 0, done 0, pix_valid 0, mem_rd_en 0, mem_addr 0, op_sel 0, out_row 0, out_col 0, line_end 0, frame_end 0; state IDLE.
- Reset asserted mid-frame: immediate return to IDLE with the reset values above; no done pulse.
- start sampled at edge N:
  - busy=1 from cycle N
  - first mem_rd_en in cycle N
  - first pix_valid in cycle N+1
- With pix_ready held at 1:
  - one pixel per cycle
  - last read in cycle N+W*H-1, last pix_valid in cycle N+W*H
  - done in cycle N+W*H+1, with busy=0 in the same cycle
- Each cycle of pix_ready=0 while pix_valid=1 adds exactly one cycle of latency.
- done and start in the same cycle: done is already in IDLE, so start is accepted; back-to-back frames are allowed.

## Test plan
- WIDTH=4, HEIGHT=2, FLIP_V=1, pix_ready=1, start one cycle → mem_addr sequence 4,5,6,7,0,1,2,3; line_end on the 4th and 8th pixels; frame_end on the 8th only; done exactly 9 cycles after the start edge.
- Same setup with FLIP_V=0 → addresses 0..7 in order; out_row/out_col go (0,0)…(1,3).
- pix_ready low for 3 cycles while the 2nd pixel is presented → pixel and sideband hold; no mem_rd_en during the stall; done arrives at 12 cycles instead of 9.
- abort asserted on the 5th read cycle → pix_valid 0 next cycle; busy 0; no done; a following start restarts at address 4.
- op_mode=3 at start, then changed to 1 mid-frame → op_sel stays 3 for the whole frame; start pulsed again mid-frame is ignored.
- Reset asserted during DRAIN → all outputs return to reset values asynchronously; after release, start begins a fresh frame at address 4.
